// File: rtl/main_control_fsm.sv
// Multi-cycle RV32I main controller. It sequences FETCH/DECODE/EXEC/MEM/WB over a shared datapath.
// It traps on illegal opcodes and on memory waits that exceed the timeout.
module main_control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter bit TRAP_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  input  logic       branch_taken,
  output logic       imem_req,
  output logic       ir_write,
  output logic       pc_write,
  output logic       alu_src_1,
  output logic       alu_src_2,
  output logic [1:0] alu_op,
  output logic [1:0] mem_to_reg,
  output logic [1:0] next_pc_sel,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       illegal_instr,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {K_ALU, K_LOAD, K_STORE, K_BRANCH} kind_t;

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);
  localparam bit TIMEOUT_EN = TRAP_EN && (MEM_TIMEOUT > 0);

  state_t        state_q, state_d;
  kind_t         kind_q, dec_kind;
  logic [CW-1:0] wait_cnt;
  logic [7:0]    bundle_q, dec_bundle;
  logic          dec_legal, wait_ack, expire;

  // Bundle layout: {alu_src_1, alu_src_2, mem_to_reg[1:0], alu_op[1:0], next_pc_sel[1:0]}
  always_comb begin
    dec_bundle = 8'b0;
    dec_kind   = K_ALU;
    dec_legal  = 1'b1;
    case (opcode)
      7'b0110011: dec_bundle = 8'b0_0_00_10_00;
      7'b0010011: dec_bundle = 8'b0_1_00_10_00;
      7'b0000011: begin dec_bundle = 8'b0_1_01_00_00; dec_kind = K_LOAD;   end
      7'b0100011: begin dec_bundle = 8'b0_1_00_00_00; dec_kind = K_STORE;  end
      7'b1100011: begin dec_bundle = 8'b0_0_00_01_00; dec_kind = K_BRANCH; end
      7'b1101111: dec_bundle = 8'b0_0_11_11_01;
      7'b1100111: dec_bundle = 8'b0_1_11_11_10;
      7'b0110111: dec_bundle = 8'b0_1_00_11_00;
      7'b0010111: dec_bundle = 8'b1_1_00_11_00;
      default:    dec_legal  = 1'b0;
    endcase
  end

  assign wait_ack = (state_q == S_FETCH) ? imem_ack : dmem_ack;
  // An ack in the expiry cycle takes priority over the timeout.
  assign expire   = TIMEOUT_EN && (wait_cnt == LIMIT - CW'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (imem_ack) state_d = S_DECODE;
                else if (expire) state_d = S_TRAP;
      S_DECODE: if (dec_legal) state_d = S_EXEC;
                else if (TRAP_EN) state_d = S_TRAP;
                else state_d = S_FETCH;
      S_EXEC:   case (kind_q)
                  K_LOAD, K_STORE: state_d = S_MEM;
                  K_BRANCH:        state_d = S_FETCH;
                  default:         state_d = S_WB;
                endcase
      S_MEM:    if (dmem_ack) state_d = (kind_q == K_LOAD) ? S_WB : S_FETCH;
                else if (expire) state_d = S_TRAP;
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      kind_q   <= K_ALU;
      wait_cnt <= '0;
      bundle_q <= 8'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        wait_cnt <= '0;
      else if ((state_q == S_FETCH || state_q == S_MEM) && !wait_ack && wait_cnt != LIMIT)
        wait_cnt <= wait_cnt + CW'(1);
      if (state_q == S_DECODE) begin
        bundle_q <= dec_bundle;
        kind_q   <= dec_kind;
      end
    end
  end

  // Strobes are decoded from the state and the bundle; reset forces them all low.
  always_comb begin
    imem_req      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    illegal_instr = 1'b0;
    alu_src_1     = bundle_q[7];
    alu_src_2     = bundle_q[6];
    mem_to_reg    = bundle_q[5:4];
    alu_op        = bundle_q[3:2];
    next_pc_sel   = bundle_q[1:0];
    state         = state_q;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_ack;
        end
        S_DECODE: if (!dec_legal && !TRAP_EN) begin
          pc_write    = 1'b1;
          next_pc_sel = 2'b00;
        end
        S_EXEC: if (kind_q == K_BRANCH) begin
          pc_write    = 1'b1;
          next_pc_sel = {1'b0, branch_taken};
        end
        S_MEM: begin
          mem_read  = (kind_q == K_LOAD);
          mem_write = (kind_q == K_STORE);
          pc_write  = (kind_q == K_STORE) && dmem_ack;
        end
        S_WB: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
        end
        S_TRAP:  illegal_instr = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
